// File: rtl/bp_pkg.sv
// Shared definitions for the 1-bit branch predictor and its resolution unit.
// The predictor table and the resolution unit both use BP_IDX_W.
package bp_pkg;

  localparam int BP_IDX_W = 4;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_fifo.sv
// Small in-order synchronous FIFO for in-flight predictions.
// The synchronous clear has priority over push and pop.
module bp_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == OCC_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + OCC_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bp_resolve.sv
// Branch resolution: matches execute outcomes against queued fetch predictions
// and issues a toggle write plus flush on a mispredict.
module bp_resolve
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [IDX_W-1:0] f_idx,
  input  logic             f_pred,
  input  logic             x_valid,
  input  logic             x_taken,
  output logic             full,
  output logic             we,
  output logic [IDX_W-1:0] w_addr,
  output logic             mispredict,
  output logic             underflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  bp_entry_t  push_entry, head;
  logic       empty, resolve, miss;

  logic             we_q, we_d;
  logic [IDX_W-1:0] w_addr_q, w_addr_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  assign push_entry.idx  = f_idx;
  assign push_entry.pred = f_pred;

  assign resolve = x_valid && !empty;
  assign miss    = resolve && (x_taken != head.pred);

  // Every younger entry is wrong-path after a mispredict, so the whole queue goes.
  bp_fifo #(
    .W     ($bits(bp_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (miss),
    .push  (f_valid),
    .pop   (resolve),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    we_d         = miss;
    mispredict_d = miss;
    w_addr_d     = miss ? head.idx : w_addr_q;
    underflow_d  = underflow_q || (x_valid && empty);
    br_count_d   = br_count_q;
    mp_count_d   = mp_count_q;
    if (resolve && !(&br_count_q)) br_count_d = br_count_q + CNT_W'(1);
    if (miss && !(&mp_count_q))    mp_count_d = mp_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      w_addr_q     <= '0;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
      br_count_q   <= '0;
      mp_count_q   <= '0;
    end else begin
      we_q         <= we_d;
      w_addr_q     <= w_addr_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
    end
  end

  assign we         = we_q;
  assign w_addr     = w_addr_q;
  assign mispredict = mispredict_q;
  assign underflow  = underflow_q;
  assign br_count   = br_count_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_bp_resolve.sv
// Directed bench for bp_resolve with hand-computed expectations.
module tb_bp_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [3:0]  f_idx;
  logic        f_pred;
  logic        x_valid;
  logic        x_taken;
  logic        full;
  logic        we;
  logic [3:0]  w_addr;
  logic        mispredict;
  logic        underflow;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  int total = 0;
  int bad   = 0;

  bp_resolve #(.DEPTH(4), .IDX_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_valid    (f_valid),
    .f_idx      (f_idx),
    .f_pred     (f_pred),
    .x_valid    (x_valid),
    .x_taken    (x_taken),
    .full       (full),
    .we         (we),
    .w_addr     (w_addr),
    .mispredict (mispredict),
    .underflow  (underflow),
    .br_count   (br_count),
    .mp_count   (mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one cycle of inputs; returns 1 ns after the capturing edge.
  task automatic step(input logic fv, input logic [3:0] fi, input logic fp,
                      input logic xv, input logic xt);
    f_valid = fv; f_idx = fi; f_pred = fp; x_valid = xv; x_taken = xt;
    @(posedge clk);
    #1;
    f_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_idx = '0; f_pred = 1'b0;
    x_valid = 1'b0; x_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", w_addr, 0);
    chk("rst_mp", mispredict, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_br", br_count, 0);
    chk("rst_mpc", mp_count, 0);
    chk("rst_full", full, 0);
    rst_n = 1'b1;

    // correct prediction
    step(1, 4'd3, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("ok_we", we, 0);
    chk("ok_mp", mispredict, 0);
    chk("ok_br", br_count, 1);
    chk("ok_mpc", mp_count, 0);

    // mispredict flushes younger entry
    step(1, 4'd5, 0, 0, 0);
    step(1, 4'd9, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("miss_we", we, 1);
    chk("miss_waddr", w_addr, 5);
    chk("miss_mp", mispredict, 1);
    chk("miss_mpc", mp_count, 1);
    chk("miss_br", br_count, 2);
    step(0, 0, 0, 0, 0);
    chk("pulse_we", we, 0);
    chk("pulse_mp", mispredict, 0);
    chk("hold_waddr", w_addr, 5);

    // fill, drop 5th, push+pop while full
    step(1, 4'd1, 1, 0, 0);
    step(1, 4'd2, 1, 0, 0);
    step(1, 4'd3, 1, 0, 0);
    chk("fill3_full", full, 0);
    step(1, 4'd4, 1, 0, 0);
    chk("fill4_full", full, 1);
    step(1, 4'd7, 0, 0, 0);
    chk("drop_full", full, 1);
    step(1, 4'd8, 1, 1, 1);
    chk("pp_full", full, 1);
    chk("pp_we", we, 0);
    chk("pp_br", br_count, 3);
    step(0, 0, 0, 1, 1);
    chk("pop_full", full, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("drain_we", we, 0);
    chk("drain_br", br_count, 6);
    step(0, 0, 0, 1, 0);
    chk("tail_we", we, 1);
    chk("tail_waddr", w_addr, 8);
    chk("tail_br", br_count, 7);
    chk("tail_mpc", mp_count, 2);

    // mispredict with simultaneous push: flush wins
    step(1, 4'd6, 1, 0, 0);
    step(1, 4'd10, 0, 1, 0);
    chk("flushpush_waddr", w_addr, 6);
    chk("flushpush_mpc", mp_count, 3);
    step(0, 0, 0, 1, 1);
    chk("flushpush_uf", underflow, 1);
    chk("flushpush_br", br_count, 8);
    chk("flushpush_we", we, 0);

    // underflow right after reset, sticky
    do_reset();
    chk("rst2_uf", underflow, 0);
    step(0, 0, 0, 1, 1);
    chk("uf_set", underflow, 1);
    chk("uf_br", br_count, 0);
    chk("uf_we", we, 0);
    step(0, 0, 0, 0, 0);
    chk("uf_sticky", underflow, 1);

    // reset while we is high
    do_reset();
    step(1, 4'd11, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("pre_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("async_we", we, 0);
    chk("async_mp", mispredict, 0);
    chk("async_br", br_count, 0);
    chk("async_mpc", mp_count, 0);
    chk("async_waddr", w_addr, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset with non-empty queue leaves it empty
    step(1, 4'd13, 1, 0, 0);
    step(1, 4'd14, 1, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 1);
    chk("rstq_uf", underflow, 1);
    chk("rstq_br", br_count, 0);
    chk("rstq_we", we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_resolve.md
# bp_resolve

Branch resolution unit for the 1-bit branch predictor: the write side of the predictor's lookup/toggle interface. It records each prediction made at fetch in a small in-order queue, compares it with the actual outcome when the branch resolves in execute, and on a mismatch issues a one-cycle toggle write (`w_addr`/`we`) to the predictor plus a flush request to the pipeline. It sits between the fetch stage, which issues predictions, and the execute stage, which resolves branches. It also keeps saturating branch and mispredict counters for performance readout.

## Interface
- `DEPTH`, default 4: in-flight prediction queue entries; power of two, 2..8.
- `IDX_W`, default 4: predictor index width; must match the predictor's 16-entry table.
- `CNT_W`, default 16: width of the performance counters.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `f_valid`, in, 1: fetch issued a conditional branch this cycle.
- `f_idx`, in, IDX_W: predictor index used for that lookup.
- `f_pred`, in, 1: predicted direction returned by the predictor (1 = taken).
- `x_valid`, in, 1: execute resolved the oldest in-flight branch this cycle.
- `x_taken`, in, 1: actual direction.
- `full`, out, 1: queue holds DEPTH entries; fetch must stall conditional branches.
- `we`, out, 1: toggle-write strobe to the predictor.
- `w_addr`, out, IDX_W: predictor entry to toggle.
- `mispredict`, out, 1: flush/redirect request.
- `underflow`, out, 1: sticky error flag.
- `br_count`, out, CNT_W: resolved branches, saturating.
- `mp_count`, out, CNT_W: mispredicts, saturating.

## Operation
- Queue entry: {idx, pred}. Push when `f_valid && !full`. A push while `full` is dropped and has no side effects.
- Resolve when `x_valid` and the queue is not empty: pop the head and compare `x_taken` with `pred`.
  - Mismatch: register `we=1`, `w_addr=head.idx`, `mispredict=1`. In the same edge, clear the entire queue, because all younger entries are wrong-path.
  - Match: pop only. `we` and `mispredict` stay 0.
- The 1-bit predictor toggles on every write, so `we` must pulse only on a mismatch. A write on a correct prediction corrupts the table.
- Push and pop in the same cycle: both apply, and the count is unchanged.
- Mispredict in the same cycle as a push: the flush wins and the pushed entry is discarded. The queue is empty afterwards.
- `x_valid` while the queue is empty: ignored. Set `underflow`, which holds until reset.
- Counters:
  - `br_count` increments on every accepted resolve.
  - `mp_count` increments on every mispredict.
  - Both saturate at all-ones.

## Timing
- Reset values: `we=0`, `w_addr=0`, `mispredict=0`, `underflow=0`, `br_count=0`, `mp_count=0`, queue empty, `full=0`.
- `full` is combinational from the occupancy count.
- `we`, `w_addr`, `mispredict`, and both counters are registered, with 1-cycle latency: a resolve at edge N produces its outputs during cycle N+1.
- `we` and `mispredict` are single-cycle pulses. Back-to-back resolves give back-to-back pulses. They cannot follow a flush, since the queue is empty.
- `w_addr` holds its last value when `we=0`.
- Write–read ordering: the predictor sees the toggle at the edge ending cycle N+1. A fetch lookup of the same index in cycle N+1 returns the old state, which is acceptable.
- Reset asserted mid-operation clears the queue and all outputs immediately, with no pending write left over.
- Pointers wrap modulo DEPTH. Occupancy uses a separate counter of width clog2(DEPTH)+1.

## Structure
- Shared package `bp_pkg`: `BP_IDX_W=4`, and the typedef of the queue entry struct {idx, pred}. The predictor and this block both import `BP_IDX_W`.
- Sub-module `bp_fifo`: a parameterised synchronous FIFO with push, pop, and a synchronous `clear`, with priority clear > push/pop. Compare logic, output registers, and counters live in `bp_resolve`.

## Test plan
- Reset, then push {idx=3, pred=1}, then resolve with `x_taken=1` → `we=0`, `mispredict=0`, `br_count=1`, `mp_count=0`.
- Push {5,0} and {9,1}, resolve the first with `x_taken=1` → next cycle `we=1`, `w_addr=5`, `mispredict=1`; queue empty; `mp_count=1`; resolving {9,1} is never required.
- Push 4 entries → `full=1`. A 5th push is dropped. Push and resolve in the same cycle (correct prediction) → occupancy stays 4, `full` stays 1.
- Mispredicting resolve in the same cycle as `f_valid` → the queue is empty afterwards, and a following `x_valid` sets `underflow=1`.
- `x_valid` with an empty queue right after reset → `underflow=1` sticky, `br_count=0`, `we=0`.
- Assert `rst_n=0` in the cycle `we` is high → `we`, `mispredict`, and the counters read 0 immediately, and the queue is empty after release.
